// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared widths, one-hot load/store bit indices, FSM state
// encoding, the MD payload record and the store byte-strobe helper used by
// the memory-access stage.
package memory_stage_pkg;

  localparam int XLEN        = 32;
  localparam int PC_WIDTH    = 32;
  localparam int LOAD_WIDTH  = 5;
  localparam int STORE_WIDTH = 3;

  // Value the MD register shows for PC/commit when it holds no instruction.
  localparam logic [PC_WIDTH-1:0] NOP_PC     = '0;
  localparam logic                NOP_COMMIT = 1'b0;

  // One-hot load op {lhu,lbu,lw,lh,lb}
  localparam int LD_LB  = 0;
  localparam int LD_LH  = 1;
  localparam int LD_LW  = 2;
  localparam int LD_LBU = 3;
  localparam int LD_LHU = 4;

  // One-hot store op {sw,sh,sb}
  localparam int ST_SB = 0;
  localparam int ST_SH = 1;
  localparam int ST_SW = 2;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_HOLD = 1'b1
  } ms_state_e;

  // Everything the stage hands to writeback apart from the valid bit.
  typedef struct packed {
    logic [XLEN-1:0]     valm;
    logic                need_dste;
    logic [4:0]          dste;
    logic [PC_WIDTH-1:0] pc;
    logic                commit;
    logic                exc;
  } md_payload_t;

  // Byte enables for a store; loads and non-memory ops give no strobes.
  function automatic logic [3:0] store_strobe(input logic [STORE_WIDTH-1:0] op,
                                               input logic [1:0]             off);
    store_strobe = 4'b0000;
    if (op[ST_SB]) begin
      store_strobe = 4'b0001 << off;
    end else if (op[ST_SH]) begin
      store_strobe = 4'b0011 << {off[1], 1'b0};
    end else if (op[ST_SW]) begin
      store_strobe = 4'b1111;
    end
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load formatter. Picks the byte (lane off) or
// halfword (lane off[1]) out of the read word and sign/zero extends it; lw
// passes the whole word. Low offset bits below the lane size are ignored.
module mem_load_align
  import memory_stage_pkg::*;
(
  input  logic [XLEN-1:0]       rdata,
  input  logic [1:0]            off,
  input  logic [LOAD_WIDTH-1:0] load_op,
  output logic [XLEN-1:0]       data
);

  logic [7:0]  byte_lane [0:3];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
      assign byte_lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = byte_lane[off];
  assign sel_half = off[1] ? {byte_lane[3], byte_lane[2]} : {byte_lane[1], byte_lane[0]};

  // Extend the selected lane according to the one-hot load op.
  always_comb begin
    data = '0;
    if (load_op[LD_LB]) begin
      data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
    end else if (load_op[LD_LBU]) begin
      data = {{(XLEN-8){1'b0}}, sel_byte};
    end else if (load_op[LD_LH]) begin
      data = {{(XLEN-16){sel_half[15]}}, sel_half};
    end else if (load_op[LD_LHU]) begin
      data = {{(XLEN-16){1'b0}}, sel_half};
    end else if (load_op[LD_LW]) begin
      data = rdata;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: memory-access pipeline stage. Issues loads/stores on a
// req/ack data port, formats load data, and registers the result into the
// MD boundary. A one-entry HOLD buffer keeps a finished access when
// writeback is stalled so the request is never re-issued.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses
// are not issued and are flagged on MD_exc_o instead).
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic                   execute_vaild_i,
  input  logic [LOAD_WIDTH-1:0]  ED_load_op_i,
  input  logic [STORE_WIDTH-1:0] ED_store_op_i,
  input  logic                   ED_sel_reg_i,
  input  logic [XLEN-1:0]        ED_valE_i,
  input  logic [XLEN-1:0]        ED_rs2_data_i,
  input  logic                   ED_need_dstE_i,
  input  logic [4:0]             ED_dstE_i,
  input  logic [PC_WIDTH-1:0]    ED_PC_i,
  input  logic                   ED_commit_i,
  input  logic                   writeback_allow_in_i,
  input  logic                   dmem_ack_i,
  input  logic [XLEN-1:0]        dmem_rdata_i,
  output logic                   memory_allow_in_o,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  output logic [XLEN-1:0]        dmem_addr_o,
  output logic [3:0]             dmem_wstrb_o,
  output logic [XLEN-1:0]        dmem_wdata_o,
  output logic                   memory_vaild_o,
  output logic [XLEN-1:0]        MD_valM_o,
  output logic                   MD_need_dstE_o,
  output logic [4:0]             MD_dstE_o,
  output logic [PC_WIDTH-1:0]    MD_PC_o,
  output logic                   MD_commit_o,
  output logic                   MD_exc_o
);

  ms_state_e   state_reg;
  logic        md_valid_reg;
  md_payload_t md_reg;
  md_payload_t hold_buf_reg;

  logic [1:0]      off;
  logic            mem_op;
  logic            misalign;
  logic            req;
  logic            done;
  logic            complete;
  logic [XLEN-1:0] load_fmt;
  md_payload_t     md_next;

  assign off    = ED_valE_i[1:0];
  assign mem_op = (|ED_load_op_i) | (|ED_store_op_i);

`ifdef MISALIGN_TRAP_EN
  logic is_half;
  logic is_word;
  assign is_half  = ED_load_op_i[LD_LH] | ED_load_op_i[LD_LHU] | ED_store_op_i[ST_SH];
  assign is_word  = ED_load_op_i[LD_LW] | ED_store_op_i[ST_SW];
  assign misalign = (is_half & off[0]) | (is_word & (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // HOLD already owns a finished access, so it never requests again.
  assign req      = (state_reg == MS_IDLE) & execute_vaild_i & mem_op & ~misalign;
  assign done     = ~mem_op | misalign | (req & dmem_ack_i);
  assign complete = execute_vaild_i & done;

  assign memory_allow_in_o = (state_reg == MS_IDLE)
                           ? (~execute_vaild_i | (done & writeback_allow_in_i))
                           : writeback_allow_in_i;

  // Data-port drive: address is live from the (stalled) ED register.
  assign dmem_req_o   = req;
  assign dmem_we_o    = req & (|ED_store_op_i);
  assign dmem_addr_o  = {ED_valE_i[XLEN-1:2], 2'b00};
  assign dmem_wstrb_o = store_strobe(ED_store_op_i, off);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi = gi + 1) begin : g_wlane
      assign dmem_wdata_o[8*gi +: 8] =
          ED_store_op_i[ST_SB] ? ED_rs2_data_i[7:0] :
          ED_store_op_i[ST_SH] ? ED_rs2_data_i[8*(gi%2) +: 8] :
          ED_store_op_i[ST_SW] ? ED_rs2_data_i[8*gi +: 8] : 8'h00;
    end
  endgenerate

  mem_load_align u_load_align (
    .rdata   (dmem_rdata_i),
    .off     (off),
    .load_op (ED_load_op_i),
    .data    (load_fmt)
  );

  // Payload the MD register (or the HOLD buffer) would take this cycle.
  always_comb begin
    md_next           = '0;
    md_next.valm      = ED_sel_reg_i ? load_fmt : ED_valE_i;
    md_next.need_dste = ED_need_dstE_i & complete & ~misalign;
    md_next.dste      = ED_dstE_i;
    md_next.pc        = ED_PC_i;
    md_next.commit    = ED_commit_i;
    md_next.exc       = complete & misalign;
  end

  // Stage FSM, HOLD buffer and MD register.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_reg        <= MS_IDLE;
      hold_buf_reg     <= '0;
      md_valid_reg     <= 1'b0;
      md_reg.valm      <= '0;
      md_reg.need_dste <= 1'b0;
      md_reg.dste      <= '0;
      md_reg.pc        <= NOP_PC;
      md_reg.commit    <= NOP_COMMIT;
      md_reg.exc       <= 1'b0;
    end else begin
      case (state_reg)
        MS_IDLE: begin
          if (writeback_allow_in_i) begin
            md_valid_reg <= complete;
            md_reg       <= md_next;
          end else if (complete) begin
            hold_buf_reg <= md_next;
            state_reg    <= MS_HOLD;
          end
        end
        MS_HOLD: begin
          if (writeback_allow_in_i) begin
            md_valid_reg <= 1'b1;
            md_reg       <= hold_buf_reg;
            state_reg    <= MS_IDLE;
          end
        end
        default: state_reg <= MS_IDLE;
      endcase
    end
  end

  assign memory_vaild_o = md_valid_reg;
  assign MD_valM_o      = md_reg.valm;
  assign MD_need_dstE_o = md_reg.need_dste;
  assign MD_dstE_o      = md_reg.dste;
  assign MD_PC_o        = md_reg.pc;
  assign MD_commit_o    = md_reg.commit;
  assign MD_exc_o       = md_reg.exc;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: self-checking bench for memory_stage. Transactions are
// described at the instruction level and checked against a reference model
// built from byte/half lane arithmetic.
`timescale 1ns/1ps
module tb_memory_stage;

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        execute_vaild_i = 1'b0;
  logic [4:0]  ED_load_op_i = '0;
  logic [2:0]  ED_store_op_i = '0;
  logic        ED_sel_reg_i = 1'b0;
  logic [31:0] ED_valE_i = '0;
  logic [31:0] ED_rs2_data_i = '0;
  logic        ED_need_dstE_i = 1'b0;
  logic [4:0]  ED_dstE_i = '0;
  logic [31:0] ED_PC_i = '0;
  logic        ED_commit_i = 1'b0;
  logic        writeback_allow_in_i = 1'b1;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        memory_allow_in_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_wstrb_o;
  logic [31:0] dmem_wdata_o;
  logic        memory_vaild_o;
  logic [31:0] MD_valM_o;
  logic        MD_need_dstE_o;
  logic [4:0]  MD_dstE_o;
  logic [31:0] MD_PC_o;
  logic        MD_commit_o;
  logic        MD_exc_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  memory_stage dut (
    .clk_i                (clk_i),
    .rst                  (rst),
    .execute_vaild_i      (execute_vaild_i),
    .ED_load_op_i         (ED_load_op_i),
    .ED_store_op_i        (ED_store_op_i),
    .ED_sel_reg_i         (ED_sel_reg_i),
    .ED_valE_i            (ED_valE_i),
    .ED_rs2_data_i        (ED_rs2_data_i),
    .ED_need_dstE_i       (ED_need_dstE_i),
    .ED_dstE_i            (ED_dstE_i),
    .ED_PC_i              (ED_PC_i),
    .ED_commit_i          (ED_commit_i),
    .writeback_allow_in_i (writeback_allow_in_i),
    .dmem_ack_i           (dmem_ack_i),
    .dmem_rdata_i         (dmem_rdata_i),
    .memory_allow_in_o    (memory_allow_in_o),
    .dmem_req_o           (dmem_req_o),
    .dmem_we_o            (dmem_we_o),
    .dmem_addr_o          (dmem_addr_o),
    .dmem_wstrb_o         (dmem_wstrb_o),
    .dmem_wdata_o         (dmem_wdata_o),
    .memory_vaild_o       (memory_vaild_o),
    .MD_valM_o            (MD_valM_o),
    .MD_need_dstE_o       (MD_need_dstE_o),
    .MD_dstE_o            (MD_dstE_o),
    .MD_PC_o              (MD_PC_o),
    .MD_commit_o          (MD_commit_o),
    .MD_exc_o             (MD_exc_o)
  );

  typedef enum int {OP_ALU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW} op_e;

  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [4:0]  dst;
    logic        need;
    logic        commit;
    int          ack_delay;  // cycles of req before the ack cycle
    int          stall;      // writeback-stall cycles after completion
  } txn_t;

  // Reference model ------------------------------------------------------
  function automatic logic [4:0] load_bits(input op_e op);
    case (op)
      OP_LB:   return 5'b00001;
      OP_LH:   return 5'b00010;
      OP_LW:   return 5'b00100;
      OP_LBU:  return 5'b01000;
      OP_LHU:  return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [2:0] store_bits(input op_e op);
    case (op)
      OP_SB:   return 3'b001;
      OP_SH:   return 3'b010;
      OP_SW:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit is_load(input op_e op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic bit is_store(input op_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic bit model_misaligned(input op_e op, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
    if (op inside {OP_LH, OP_LHU, OP_SH}) return addr[0];
    if (op inside {OP_LW, OP_SW}) return addr[1:0] != 2'b00;
    return 1'b0;
`else
    return (op == OP_ALU) && (addr === 32'hx);
`endif
  endfunction

  function automatic logic [31:0] model_load(input op_e op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    b = (rdata >> (8 * addr[1:0])) & 32'h0000_00FF;
    h = (rdata >> (16 * addr[1])) & 32'h0000_FFFF;
    case (op)
      OP_LB:   return b[7] ? (b | 32'hFFFF_FF00) : b;
      OP_LBU:  return b;
      OP_LH:   return h[15] ? (h | 32'hFFFF_0000) : h;
      OP_LHU:  return h;
      OP_LW:   return rdata;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] model_strobe(input op_e op, input logic [31:0] addr);
    case (op)
      OP_SB:   return 4'(1 << addr[1:0]);
      OP_SH:   return addr[1] ? 4'b1100 : 4'b0011;
      OP_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input op_e op, input logic [31:0] rs2);
    case (op)
      OP_SB:   return rs2[7:0] * 32'h0101_0101;
      OP_SH:   return rs2[15:0] * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  // Drives one instruction through the stage, starting just after a rising
  // edge, and scores the port activity and the final MD contents.
  task automatic run_txn(input txn_t t, input string name);
    bit          mem;
    bit          mis;
    int          delay;
    int          req_cycles;
    logic        exp_req;
    logic        exp_allow;
    logic [31:0] exp_val;
    mem     = is_load(t.op) || is_store(t.op);
    mis     = model_misaligned(t.op, t.addr);
    delay   = (mem && !mis) ? t.ack_delay : 0;
    exp_req = mem && !mis;
    exp_val = is_load(t.op) ? model_load(t.op, t.addr, t.rdata) : t.addr;
    req_cycles = 0;

    execute_vaild_i = 1'b1;
    ED_load_op_i    = load_bits(t.op);
    ED_store_op_i   = store_bits(t.op);
    ED_sel_reg_i    = is_load(t.op);
    ED_valE_i       = t.addr;
    ED_rs2_data_i   = t.rs2;
    ED_need_dstE_i  = t.need;
    ED_dstE_i       = t.dst;
    ED_PC_i         = t.pc;
    ED_commit_i     = t.commit;

    for (int c = 0; c <= delay; c++) begin
      dmem_ack_i           = (c == delay) && exp_req;
      dmem_rdata_i         = dmem_ack_i ? t.rdata : $urandom;
      writeback_allow_in_i = (c < delay) ? 1'b1 : (t.stall == 0);
      exp_allow            = (c < delay) ? 1'b0 : (t.stall == 0);
      #4;
      checks++;
      if (dmem_req_o !== exp_req) begin
        errors++;
        $display("FAIL %s.req cycle %0d: got %b expected %b", name, c, dmem_req_o, exp_req);
      end
      if (dmem_req_o === 1'b1) req_cycles++;
      checks++;
      if (memory_allow_in_o !== exp_allow) begin
        errors++;
        $display("FAIL %s.allow_in cycle %0d: got %b expected %b", name, c, memory_allow_in_o, exp_allow);
      end
      if (c == 0 && exp_req) begin
        checks++;
        if (dmem_addr_o !== {t.addr[31:2], 2'b00}) begin
          errors++;
          $display("FAIL %s.addr: got %h expected %h", name, dmem_addr_o, {t.addr[31:2], 2'b00});
        end
        checks++;
        if (dmem_wstrb_o !== model_strobe(t.op, t.addr)) begin
          errors++;
          $display("FAIL %s.wstrb: got %b expected %b", name, dmem_wstrb_o, model_strobe(t.op, t.addr));
        end
        checks++;
        if (dmem_we_o !== is_store(t.op)) begin
          errors++;
          $display("FAIL %s.we: got %b expected %b", name, dmem_we_o, is_store(t.op));
        end
        if (is_store(t.op)) begin
          checks++;
          if (dmem_wdata_o !== model_wdata(t.op, t.rs2)) begin
            errors++;
            $display("FAIL %s.wdata: got %h expected %h", name, dmem_wdata_o, model_wdata(t.op, t.rs2));
          end
        end
      end
      @(posedge clk_i); #1;
      if (c < delay) begin
        checks++;
        if (memory_vaild_o !== 1'b0) begin
          errors++;
          $display("FAIL %s.bubble cycle %0d: memory_vaild got %b expected 0", name, c, memory_vaild_o);
        end
      end
    end

    // Writeback stalled: the finished access waits without re-requesting.
    for (int h = 1; h <= t.stall; h++) begin
      dmem_ack_i           = 1'($urandom_range(0, 1));
      dmem_rdata_i         = $urandom;
      writeback_allow_in_i = (h == t.stall);
      #4;
      checks++;
      if (dmem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL %s.hold_req cycle %0d: got %b expected 0", name, h, dmem_req_o);
      end
      if (dmem_req_o === 1'b1) req_cycles++;
      checks++;
      if (memory_allow_in_o !== writeback_allow_in_i) begin
        errors++;
        $display("FAIL %s.hold_allow cycle %0d: got %b expected %b", name, h, memory_allow_in_o, writeback_allow_in_i);
      end
      @(posedge clk_i); #1;
    end
    dmem_ack_i = 1'b0;

    checks++;
    if (req_cycles != (exp_req ? delay + 1 : 0)) begin
      errors++;
      $display("FAIL %s.req_count: got %0d expected %0d", name, req_cycles, exp_req ? delay + 1 : 0);
    end
    checks++;
    if (memory_vaild_o !== 1'b1) begin
      errors++;
      $display("FAIL %s.md_valid: got %b expected 1", name, memory_vaild_o);
    end
    if (!mis) begin
      checks++;
      if (MD_valM_o !== exp_val) begin
        errors++;
        $display("FAIL %s.valM: got %h expected %h", name, MD_valM_o, exp_val);
      end
    end
    checks++;
    if (MD_need_dstE_o !== (t.need & !mis)) begin
      errors++;
      $display("FAIL %s.need_dstE: got %b expected %b", name, MD_need_dstE_o, t.need & !mis);
    end
    checks++;
    if (MD_dstE_o !== t.dst || MD_PC_o !== t.pc || MD_commit_o !== t.commit) begin
      errors++;
      $display("FAIL %s.sideband: got dst=%0d pc=%h commit=%b expected dst=%0d pc=%h commit=%b",
               name, MD_dstE_o, MD_PC_o, MD_commit_o, t.dst, t.pc, t.commit);
    end
    checks++;
    if (MD_exc_o !== mis) begin
      errors++;
      $display("FAIL %s.exc: got %b expected %b", name, MD_exc_o, mis);
    end
    $display("txn %-12s op=%0d addr=%08h delay=%0d stall=%0d reqs=%0d valM=%08h exc=%b",
             name, t.op, t.addr, delay, t.stall, req_cycles, MD_valM_o, MD_exc_o);
  endtask

  function automatic txn_t mk(input op_e op, input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [31:0] rdata, input int ack_delay, input int stall);
    txn_t t;
    t.op = op;  t.addr = addr;  t.rs2 = rs2;  t.rdata = rdata;
    t.pc = $urandom;  t.dst = 5'($urandom_range(1, 31));
    t.need = is_load(op) || op == OP_ALU;  t.commit = 1'b1;
    t.ack_delay = ack_delay;  t.stall = stall;
    return t;
  endfunction

  task automatic go_idle();
    execute_vaild_i      = 1'b0;
    ED_load_op_i         = '0;
    ED_store_op_i        = '0;
    dmem_ack_i           = 1'b0;
    writeback_allow_in_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  // Tests ------------------------------------------------------------------
  task automatic test_reset();
    @(posedge clk_i); @(posedge clk_i); #1;
    checks++;
    if (memory_vaild_o !== 1'b0 || MD_valM_o !== 32'h0 || MD_need_dstE_o !== 1'b0 ||
        MD_dstE_o !== 5'd0 || MD_exc_o !== 1'b0) begin
      errors++;
      $display("FAIL reset.md: got v=%b valM=%h need=%b dst=%0d exc=%b expected all zero",
               memory_vaild_o, MD_valM_o, MD_need_dstE_o, MD_dstE_o, MD_exc_o);
    end
    // nop PC and nop commit marker are both zero in this codebase
    checks++;
    if (MD_PC_o !== 32'h0 || MD_commit_o !== 1'b0) begin
      errors++;
      $display("FAIL reset.nop: got pc=%h commit=%b expected pc=0 commit=0", MD_PC_o, MD_commit_o);
    end
    rst = 1'b0;
    #4;
    checks++;
    if (dmem_req_o !== 1'b0 || memory_allow_in_o !== 1'b1) begin
      errors++;
      $display("FAIL reset.idle: got req=%b allow=%b expected req=0 allow=1", dmem_req_o, memory_allow_in_o);
    end
    @(posedge clk_i); #1;
    $display("txn reset        MD cleared");
  endtask

  task automatic test_lw_same_cycle();
    run_txn(mk(OP_LW, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 0), "lw_ack0");
    checks++;
    if (MD_valM_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL lw_ack0.const: got %h expected deadbeef", MD_valM_o);
    end
  endtask

  task automatic test_byte_extend();
    run_txn(mk(OP_LB, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0), "lb_sign");
    checks++;
    if (MD_valM_o !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_sign.const: got %h expected ffffff80", MD_valM_o);
    end
    run_txn(mk(OP_LBU, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0), "lbu_zero");
    checks++;
    if (MD_valM_o !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_zero.const: got %h expected 00000080", MD_valM_o);
    end
  endtask

  task automatic test_store_half();
    run_txn(mk(OP_SH, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0, 0), "sh_upper");
    run_txn(mk(OP_SB, 32'h0000_0311, 32'h0000_005A, 32'h0, 1, 0), "sb_lane1");
  endtask

  task automatic test_delayed_ack();
    run_txn(mk(OP_LW, 32'h0000_0408, 32'h0, 32'h0BAD_F00D, 2, 0), "lw_delay");
  endtask

  task automatic test_hold();
    run_txn(mk(OP_SW, 32'h0000_0500, 32'hCAFE_1234, 32'h0, 0, 2), "sw_hold");
    run_txn(mk(OP_LHU, 32'h0000_0602, 32'h0, 32'h9876_5432, 1, 1), "lhu_hold");
  endtask

  task automatic test_back_to_back();
    run_txn(mk(OP_ALU, 32'h1111_2222, 32'h0, 32'h0, 0, 0), "b2b_alu");
    run_txn(mk(OP_LH,  32'h0000_0700, 32'h0, 32'h1234_F00F, 0, 0), "b2b_lh");
    run_txn(mk(OP_ALU, 32'h3333_4444, 32'h0, 32'h0, 0, 0), "b2b_alu2");
    run_txn(mk(OP_SB,  32'h0000_0803, 32'h0000_00EE, 32'h0, 0, 0), "b2b_sb");
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    run_txn(mk(OP_LW, 32'h0000_0101, 32'h0, 32'h1357_9BDF, 0, 0), "lw_trap");
    checks++;
    if (MD_exc_o !== 1'b1 || MD_need_dstE_o !== 1'b0) begin
      errors++;
      $display("FAIL lw_trap.const: got exc=%b need=%b expected exc=1 need=0", MD_exc_o, MD_need_dstE_o);
    end
`else
    run_txn(mk(OP_LH, 32'h0000_0103, 32'h0, 32'h8001_1234, 0, 0), "lh_odd");
    checks++;
    if (MD_valM_o !== 32'hFFFF_8001) begin
      errors++;
      $display("FAIL lh_odd.const: got %h expected ffff8001", MD_valM_o);
    end
    run_txn(mk(OP_LW, 32'h0000_0101, 32'h0, 32'h1357_9BDF, 0, 0), "lw_odd");
    checks++;
    if (MD_valM_o !== 32'h1357_9BDF || MD_exc_o !== 1'b0) begin
      errors++;
      $display("FAIL lw_odd.const: got %h exc=%b expected 13579bdf exc=0", MD_valM_o, MD_exc_o);
    end
`endif
  endtask

  task automatic test_random();
    txn_t t;
    for (int i = 0; i < 80; i++) begin
      t = mk(op_e'($urandom_range(0, 8)), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2));
      t.need   = 1'($urandom_range(0, 1));
      t.commit = 1'($urandom_range(0, 1));
      run_txn(t, "random");
    end
  endtask

  task automatic test_reset_mid_request();
    // Reset while a load is waiting for its ack.
    execute_vaild_i      = 1'b1;
    ED_load_op_i         = load_bits(OP_LW);
    ED_store_op_i        = '0;
    ED_valE_i            = 32'h0000_0300;
    writeback_allow_in_i = 1'b1;
    dmem_ack_i           = 1'b0;
    #4;
    checks++;
    if (dmem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid.req_before: got %b expected 1", dmem_req_o);
    end
    @(posedge clk_i); #1;
    rst = 1'b1;
    execute_vaild_i = 1'b0;
    #4;
    checks++;
    if (dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid.req_in_reset: got %b expected 0", dmem_req_o);
    end
    @(posedge clk_i); #1;
    rst = 1'b0;
    checks++;
    if (memory_vaild_o !== 1'b0 || MD_valM_o !== 32'h0 || MD_need_dstE_o !== 1'b0 ||
        MD_dstE_o !== 5'd0 || MD_PC_o !== 32'h0 || MD_commit_o !== 1'b0 || MD_exc_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid.md: got v=%b valM=%h need=%b dst=%0d pc=%h commit=%b exc=%b expected reset values",
               memory_vaild_o, MD_valM_o, MD_need_dstE_o, MD_dstE_o, MD_PC_o, MD_commit_o, MD_exc_o);
    end
    // Reset while a finished store sits in HOLD: stage must come back empty.
    execute_vaild_i      = 1'b1;
    ED_load_op_i         = '0;
    ED_store_op_i        = store_bits(OP_SW);
    ED_valE_i            = 32'h0000_0400;
    dmem_ack_i           = 1'b1;
    writeback_allow_in_i = 1'b0;
    @(posedge clk_i); #1;
    rst             = 1'b1;
    execute_vaild_i = 1'b0;
    dmem_ack_i      = 1'b0;
    @(posedge clk_i); #1;
    rst = 1'b0;
    #4;
    checks++;
    if (memory_allow_in_o !== 1'b1 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold.idle: got allow=%b req=%b expected allow=1 req=0", memory_allow_in_o, dmem_req_o);
    end
    writeback_allow_in_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (memory_vaild_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold.no_replay: memory_vaild got %b expected 0", memory_vaild_o);
    end
    $display("txn reset_mid    MD cleared, FSM idle");
  endtask

  initial begin
    test_reset();
    test_lw_same_cycle();
    test_byte_extend();
    test_store_half();
    test_delayed_ack();
    test_hold();
    test_back_to_back();
    test_misalign();
    test_random();
    go_idle();
    test_reset_mid_request();
    go_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
